// File: rtl/acc_buffer.sv
// acc_buffer: multi-channel accumulator buffer with optional saturation, sticky overflow
// flags and a valid/ready drain port that streams entry rows 0..DEPTH-1.
module acc_buffer #(
    parameter int NUM_CH            = 4,
    parameter int DEPTH             = 8,
    parameter int IN_SUM_BITWIDTH   = 32,
    parameter int ACC_DATA_BITWIDTH = 40,
    parameter int SATURATE          = 1,
    parameter int CLR_ON_READ       = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  wrt_en,
    input  logic                                  acc_logic,
    input  logic [$clog2(DEPTH)-1:0]              wr_addr,
    input  logic [NUM_CH*IN_SUM_BITWIDTH-1:0]     part_sum_in,
    output logic                                  wr_drop,
    input  logic                                  drain_start,
    output logic                                  busy,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [NUM_CH*ACC_DATA_BITWIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH)-1:0]              out_addr,
    output logic                                  out_last,
    output logic                                  drain_done,
    output logic [NUM_CH-1:0]                     ovf
);
    localparam int AW  = $clog2(DEPTH);
    localparam int IN  = IN_SUM_BITWIDTH;
    localparam int ACC = ACC_DATA_BITWIDTH;
    localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [ACC-1:0] ACC_MAX   = {1'b0, {(ACC-1){1'b1}}};
    localparam logic [ACC-1:0] ACC_MIN   = {1'b1, {(ACC-1){1'b0}}};

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    state_t            r_state, w_next;
    logic [ACC-1:0]    r_mem [NUM_CH][DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [NUM_CH-1:0] r_ovf;
    logic              r_drop, r_done;
    logic [ACC-1:0]    w_res [NUM_CH];
    logic [NUM_CH-1:0] w_of;
    logic              w_wr, w_fire, w_last, w_start;

    assign w_wr    = wrt_en && (r_state == S_IDLE);
    assign w_start = drain_start && (r_state == S_IDLE);
    assign w_fire  = out_ready && (r_state == S_DRAIN);
    assign w_last  = (r_rd_ptr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == S_IDLE) ? (drain_start ? S_DRAIN : S_IDLE)
                                     : ((out_ready && w_last) ? S_IDLE : S_DRAIN);
    end

    always_comb begin
        busy       = (r_state == S_DRAIN);
        out_valid  = (r_state == S_DRAIN);
        out_last   = (r_state == S_DRAIN) && w_last;
        out_addr   = r_rd_ptr;
        wr_drop    = r_drop;
        drain_done = r_done;
        ovf        = r_ovf;
    end

    // Overflow is only possible when adding two same-signed operands.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [IN-1:0]  w_in;
        logic signed [ACC-1:0] w_ext;
        logic [ACC-1:0]        w_old, w_sum;
        assign w_in    = part_sum_in[c*IN +: IN];
        assign w_ext   = ACC'(w_in);
        assign w_old   = r_mem[c][wr_addr];
        assign w_sum   = w_old + w_ext;
        assign w_of[c] = acc_logic && (w_old[ACC-1] == w_ext[ACC-1]) && (w_sum[ACC-1] != w_old[ACC-1]);
        assign w_res[c] = !acc_logic ? w_ext
                        : (w_of[c] && SATURATE != 0) ? (w_old[ACC-1] ? ACC_MIN : ACC_MAX)
                        : w_sum;
        assign out_data[c*ACC +: ACC] = r_mem[c][r_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int d = 0; d < DEPTH; d++)
                    r_mem[c][d] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_wr)
                    r_mem[c][wr_addr] <= w_res[c];
                else if (w_fire && CLR_ON_READ != 0)
                    r_mem[c][r_rd_ptr] <= '0;
            end
        end
    end

    // A write coinciding with drain_start still reports its own overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_ovf    <= '0;
            r_drop   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_rd_ptr <= w_start ? '0 : (w_fire ? r_rd_ptr + 1'b1 : r_rd_ptr);
            r_ovf    <= (w_start ? '0 : r_ovf) | (w_wr ? w_of : '0);
            r_drop   <= wrt_en && (r_state == S_DRAIN);
            r_done   <= w_fire && w_last;
        end
    end
endmodule

// File: tb/tb_acc_buffer.sv
// tb_acc_buffer: directed checks of acc_buffer in its default 40-bit form and in
// 32-bit saturating / wrapping forms driven with identical stimulus.
module tb_acc_buffer;
    logic         clk = 1'b0;
    logic         reset, wrt_en, acc_logic, drain_start, out_ready;
    logic [2:0]   wr_addr;
    logic [127:0] part_sum_in;

    logic         drop0, busy0, valid0, last0, done0;
    logic [2:0]   addr0;
    logic [159:0] d0;
    logic [3:0]   ovf0;
    logic         drop1, busy1, valid1, last1, done1;
    logic [2:0]   addr1;
    logic [127:0] d1;
    logic [3:0]   ovf1;
    logic         drop2, busy2, valid2, last2, done2;
    logic [2:0]   addr2;
    logic [127:0] d2;
    logic [3:0]   ovf2;

    logic [39:0] r0 [8];
    logic        rest0 [8];
    logic [31:0] r1 [8];
    logic [31:0] r2 [8];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    acc_buffer u0 (
        .clk(clk), .reset(reset), .wrt_en(wrt_en), .acc_logic(acc_logic), .wr_addr(wr_addr),
        .part_sum_in(part_sum_in), .wr_drop(drop0), .drain_start(drain_start), .busy(busy0),
        .out_valid(valid0), .out_ready(out_ready), .out_data(d0), .out_addr(addr0),
        .out_last(last0), .drain_done(done0), .ovf(ovf0)
    );

    acc_buffer #(.ACC_DATA_BITWIDTH(32), .SATURATE(1)) u1 (
        .clk(clk), .reset(reset), .wrt_en(wrt_en), .acc_logic(acc_logic), .wr_addr(wr_addr),
        .part_sum_in(part_sum_in), .wr_drop(drop1), .drain_start(drain_start), .busy(busy1),
        .out_valid(valid1), .out_ready(out_ready), .out_data(d1), .out_addr(addr1),
        .out_last(last1), .drain_done(done1), .ovf(ovf1)
    );

    acc_buffer #(.ACC_DATA_BITWIDTH(32), .SATURATE(0)) u2 (
        .clk(clk), .reset(reset), .wrt_en(wrt_en), .acc_logic(acc_logic), .wr_addr(wr_addr),
        .part_sum_in(part_sum_in), .wr_drop(drop2), .drain_start(drain_start), .busy(busy2),
        .out_valid(valid2), .out_ready(out_ready), .out_data(d2), .out_addr(addr2),
        .out_last(last2), .drain_done(done2), .ovf(ovf2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic wr(input logic [2:0] a, input logic acc, input logic [31:0] v);
        wrt_en = 1'b1;
        acc_logic = acc;
        wr_addr = a;
        part_sum_in = {96'd0, v};
        @(negedge clk);
        wrt_en = 1'b0;
    endtask

    // pat 0: ready always high; pat 1: ready 1,0,0 repeating. abort_at >= 0 resets mid-drain.
    task automatic drain(input int pat, input bit inj, input int abort_at);
        int n = 0;
        bit stalled = 0, fin = 0, aborted = 0;
        logic [39:0] hd = '0;
        logic [2:0]  ha = '0;
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        chk("busy_on", busy0, 1);
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            if (abort_at >= 0 && addr0 == 3'(abort_at)) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("abort_busy", busy0, 0);
                chk("abort_valid", valid0, 0);
                chk("abort_addr", addr0, 0);
                for (int k = 0; k < 3; k++) begin
                    chk("abort_no_done", done0, 0);
                    @(negedge clk);
                end
                aborted = 1;
                fin = 1;
            end else begin
                if (stalled) begin
                    chk("stall_addr", addr0, ha);
                    chk("stall_data", d0[39:0], hd);
                end
                if (inj && cyc == 1) begin
                    chk("wr_drop", drop0, 1);
                    wrt_en = 1'b0;
                end
                if (inj && cyc == 0) begin
                    wrt_en = 1'b1;
                    acc_logic = 1'b1;
                    wr_addr = 3'd3;
                    part_sum_in = {4{32'd1000}};
                end
                out_ready = (pat == 0) || (cyc % 3 == 0);
                stalled = valid0 && !out_ready;
                ha = addr0;
                hd = d0[39:0];
                if (valid0 && out_ready) begin
                    chk("row_addr", addr0, n);
                    chk("row_last", last0, n == 7);
                    r0[n] = d0[39:0];
                    rest0[n] = |d0[159:40];
                    r1[n] = d1[31:0];
                    r2[n] = d2[31:0];
                    n++;
                    fin = (n == 8);
                end
                @(negedge clk);
            end
        end
        out_ready = 1'b0;
        if (!aborted) begin
            chk("drain_rows", n, 8);
            chk("drain_done", done0, 1);
            chk("busy_off", busy0, 0);
            @(negedge clk);
            chk("done_pulse", done0, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        wrt_en = 1'b0;
        acc_logic = 1'b0;
        wr_addr = '0;
        part_sum_in = '0;
        drain_start = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy0, 0);
        chk("rst_valid", valid0, 0);
        chk("rst_last", last0, 0);
        chk("rst_drop", drop0, 0);
        chk("rst_done", done0, 0);
        chk("rst_addr", addr0, 0);
        chk("rst_ovf", ovf0, 0);

        drain(0, 0, -1);
        for (int i = 0; i < 8; i++) begin
            chk("zero_ch0", r0[i], 0);
            chk("zero_rest", rest0[i], 0);
        end

        wr(3'd3, 1'b0, 32'd5);
        wr(3'd3, 1'b1, -32'sd7);
        wr(3'd3, 1'b1, 32'd100);
        drain(0, 0, -1);
        chk("acc_98", r0[3], 40'd98);
        drain(0, 0, -1);
        chk("clr_on_read", r0[3], 0);

        wr(3'd2, 1'b0, 32'h7FFF_FFF0);
        wr(3'd2, 1'b1, 32'h0000_0020);
        chk("ovf_sat", ovf1, 4'b0001);
        chk("ovf_wrap", ovf2, 4'b0001);
        chk("ovf_wide", ovf0, 4'b0000);
        wr(3'd1, 1'b0, 32'h8000_0000);
        wr(3'd1, 1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) wr(3'd4, 1'b1, 32'hFFFF_FFFF);
        chk("ovf_sext", ovf0, 4'b0000);
        drain(0, 0, -1);
        chk("ovf_cleared", ovf1, 4'b0000);
        chk("sat_pos", r1[2], 32'h7FFF_FFFF);
        chk("wrap_pos", r2[2], 32'h8000_0010);
        chk("wide_pos", r0[2], 40'h00_8000_0010);
        chk("sat_neg", r1[1], 32'h8000_0000);
        chk("wrap_neg", r2[1], 32'h7FFF_FFFF);
        chk("sext_m4", r0[4], 40'hFF_FFFF_FFFC);
        chk("sext_m4_32", r1[4], 32'hFFFF_FFFC);

        for (int i = 0; i < 8; i++) wr(3'(i), 1'b0, 32'(10 + i));
        drain(1, 1, -1);
        for (int i = 0; i < 8; i++) chk("stall_row", r0[i], 40'(10 + i));

        wr(3'd5, 1'b0, 32'd9);
        wr(3'd7, 1'b0, 32'd9);
        drain(0, 0, 4);
        wr(3'd0, 1'b0, 32'd9);
        drain(0, 0, -1);
        chk("post_rst_wr", r0[0], 40'd9);
        chk("post_rst_5", r0[5], 0);
        chk("post_rst_7", r0[7], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
